// File: rtl/water_light_monitor_pkg.sv
// Shared types and constants for the flowing-light monitor.
// Holds FSM state encodings, position width and 7-segment glyphs.
package water_light_monitor_pkg;

  localparam int POS_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_e;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b100_0000;
  localparam logic [6:0] SEG_1     = 7'b111_1001;
  localparam logic [6:0] SEG_2     = 7'b010_0100;
  localparam logic [6:0] SEG_3     = 7'b011_0000;
  localparam logic [6:0] SEG_4     = 7'b001_1001;
  localparam logic [6:0] SEG_5     = 7'b001_0010;
  localparam logic [6:0] SEG_6     = 7'b000_0010;
  localparam logic [6:0] SEG_7     = 7'b111_1000;
  localparam logic [6:0] SEG_8     = 7'b000_0000;
  localparam logic [6:0] SEG_9     = 7'b001_0000;
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;

endpackage

// File: rtl/water_light_monitor_if.sv
// LED-pattern in / status out bundle for the flowing-light monitor.
// master: pattern source + display sink; slave: the monitor itself.
interface water_light_monitor_if;
  import water_light_monitor_pkg::*;

  logic [15:0]      led_in;
  logic             lap_hold;
  logic [POS_W-1:0] pos;
  logic [7:0]       lap_bcd;
  logic             err;
  logic [6:0]       seg_hi;
  logic [6:0]       seg_lo;

  modport master (
    output led_in, lap_hold,
    input  pos, lap_bcd, err,
    input  seg_hi, seg_lo
  );

  modport slave (
    input  led_in, lap_hold,
    output pos, lap_bcd, err,
    output seg_hi, seg_lo
  );

endinterface

// File: rtl/water_light_monitor_bcd_to_seg7.sv
// One BCD digit to active-low 7-segment glyph, blank for codes >9.
// Ports: bcd_i (4b BCD), seg_o (7b {g..a}, active-low).
module water_light_monitor_bcd_to_seg7
  import water_light_monitor_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/water_light_monitor.sv
// Checks the 16-LED flowing-light sequence, counts BCD laps, flags faults.
// Ports: clk_1hz, reset (sync, active-low), bus (slave modport:
//   led_in, lap_hold in; pos, lap_bcd, err, seg_hi, seg_lo out).
// Macro WATER_LIGHT_SEG_EN: build the seg decoders, else segs are blank.
module water_light_monitor
  import water_light_monitor_pkg::*;
#(
  parameter int LAP_WRAP = 99,
  parameter int POS_MAX  = 16
) (
  input  logic                 clk_1hz,
  input  logic                 reset,
  water_light_monitor_if.slave bus
);

  localparam logic [7:0] WRAP_BCD = {
    4'(LAP_WRAP / 10), 4'(LAP_WRAP % 10)
  };
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(POS_MAX);

  state_e           state_q;
  logic [POS_W-1:0] pos_q;
  logic [7:0]       lap_q;
  logic [7:0]       lap_d;
  logic             err_q;

  logic             dec_vld_d;
  logic [POS_W-1:0] dec_pos_d;
  logic [POS_W-1:0] exp_pos_d;
  logic             hit_d;
  logic             start_d;

  // All-ones is position 0; a single low bit k is position k+1.
  always_comb begin
    dec_vld_d = 1'b0;
    dec_pos_d = '0;
    if (&bus.led_in) begin
      dec_vld_d = 1'b1;
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (bus.led_in == ~(16'h0001 << k)) begin
          dec_vld_d = 1'b1;
          dec_pos_d = POS_W'(k + 1);
        end
      end
    end
  end

  assign exp_pos_d = (pos_q == POS_LAST) ? '0
                                         : pos_q + 1'b1;
  assign hit_d   = dec_vld_d && (dec_pos_d == exp_pos_d);
  assign start_d = dec_vld_d && (dec_pos_d == '0);

  always_comb begin
    if (lap_q == WRAP_BCD) begin
      lap_d = 8'h00;
    end else if (lap_q[3:0] == 4'd9) begin
      lap_d = {lap_q[7:4] + 4'd1, 4'd0};
    end else begin
      lap_d = {lap_q[7:4], lap_q[3:0] + 4'd1};
    end
  end

  always_ff @(posedge clk_1hz) begin
    if (!reset) begin
      state_q <= IDLE;
      pos_q   <= '0;
      lap_q   <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_d) begin
            state_q <= TRACK;
            pos_q   <= '0;
          end
        end
        TRACK: begin
          if (hit_d) begin
            pos_q <= dec_pos_d;
            // wrap back to 0 closes a sweep
            if (exp_pos_d == '0 && !bus.lap_hold) begin
              lap_q <= lap_d;
            end
          end else begin
            state_q <= FAULT;
            err_q   <= 1'b1;
          end
        end
        FAULT: begin
          if (start_d) begin
            state_q <= TRACK;
            pos_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pos     = pos_q;
  assign bus.lap_bcd = lap_q;
  assign bus.err     = err_q;

`ifdef WATER_LIGHT_SEG_EN
  water_light_monitor_bcd_to_seg7 u_seg_hi (
    .bcd_i (lap_q[7:4]),
    .seg_o (bus.seg_hi)
  );
  water_light_monitor_bcd_to_seg7 u_seg_lo (
    .bcd_i (lap_q[3:0]),
    .seg_o (bus.seg_lo)
  );
`else
  assign bus.seg_hi = SEG_BLANK;
  assign bus.seg_lo = SEG_BLANK;
`endif

endmodule

// File: doc/water_light_monitor.md
Name: water_light_monitor

Overview:
- Downstream consumer of the 16-LED flowing-light pattern. Samples the active-low LED vector on each clk_1hz edge and decodes it to a position (0..16).
- Checks that the pattern advances exactly one step per tick, counts completed sweeps as a 2-digit BCD lap count, and flags sequence faults.
- Drives board 7-segment digits showing the lap count.

Parameters:
- LAP_WRAP, 99, BCD lap value after which the count wraps to 00; legal range 1..99.
- POS_MAX, 16, highest position index; the sequence length is POS_MAX+1.

Ports:
- clk_1hz  in  1  clock, same tick that advances the LED pattern
- reset  in  1  synchronous, active-low
- led_in  in  16  active-low LED pattern from the flowing-light stage
- lap_hold  in  1  high = freeze lap counter; tracking and checking continue
- pos  out  5  registered decoded position, 0..16
- lap_bcd  out  8  [7:4] tens, [3:0] ones, BCD
- err  out  1  sticky fault flag
- seg_hi  out  7  active-low segments {g..a}, tens digit
- seg_lo  out  7  active-low segments {g..a}, ones digit

Behaviour:
- Decode (combinational):
  - All-ones -> position 0, valid.
  - Exactly one zero at bit k -> position k+1, valid.
  - Any other value -> invalid.
- Reset (reset==0 at posedge, wins over everything):
  - pos=0, lap_bcd=8'h00, err=0, state=IDLE.
  - seg outputs show "00", i.e. 7'b100_0000 each.
- FSM, one transition per posedge:
  - IDLE: valid position 0 -> TRACK. Anything else stays in IDLE; err is not set.
  - TRACK: expected = (pos==POS_MAX) ? 0 : pos+1.
    - Decoded == expected -> stay in TRACK, load pos.
    - Expected == 0 and matched -> lap increment, unless lap_hold.
    - Valid mismatch or invalid -> FAULT, err=1, pos holds.
  - FAULT: valid position 0 -> TRACK, load pos=0, no lap increment. Otherwise stay; pos holds.
- Position register:
  - pos loads only on a valid, accepted sample.
  - Latency: pos reflects led_in sampled at the previous edge (1 cycle).
- Lap counter:
  - BCD increment: ones 9 -> 0 with tens+1.
  - When lap_bcd equals LAP_WRAP in BCD, the next increment gives 00.
  - lap_hold during a wrap-step: lap unchanged, the sweep is lost, no error.
- err is sticky: cleared only by reset. A return to TRACK does not clear it.
- seg_hi/seg_lo are combinational from lap_bcd. BCD codes >9 cannot occur; decoder default is blank, 7'b111_1111.
- Reset asserted mid-sweep: next cycle is IDLE. Tracking resumes only once an all-ones pattern is seen.

Optional Feature:
- Macro: WATER_LIGHT_SEG_EN
- Defined: the seg_hi/seg_lo decoders are instantiated as above.
- Undefined: the decoders are removed and seg_hi=seg_lo=7'b111_1111 (all off) constantly. All other outputs are unchanged.

Decomposition:
- Shared package:
  - FSM state encodings IDLE=2'd0, TRACK=2'd1, FAULT=2'd2.
  - POS_W=5.
  - Active-low 7-segment constants for digits 0..9 and blank.
- Natural sub-module: bcd_to_seg7 (4-bit BCD in, 7-bit active-low out), instantiated twice under the macro.

Test Plan:
- Reset, then feed 17 legal steps (FFFF, FFFE, FFFD … 7FFF), then FFFF -> pos tracks 0..16 then 0 with 1-cycle lag; lap_bcd=01; err=0.
- Run 100 full sweeps from reset with LAP_WRAP=99 -> lap_bcd reaches 8'h99, then 8'h00 on the 100th; seg_hi=seg_lo=7'b100_0000 when WATER_LIGHT_SEG_EN is defined.
- In TRACK at pos=3, inject FFF3 (two zeros) -> state FAULT, err=1, pos stays 3. Then FFFF -> TRACK, pos=0, err stays 1.
- In TRACK at pos=5, inject FFDF (skip to pos 6 instead of 5->... is legal; use FF7F, pos 8) -> FAULT, err=1, lap unchanged.
- Hold lap_hold=1 across the 7FFF->FFFF step -> lap_bcd unchanged, err=0. Release, run one more sweep -> lap increments by 1.
- Assert reset at pos=9 mid-sweep, release while led_in=FEFF -> IDLE, pos=0, lap=00. Stays IDLE until FFFF, then tracks normally.
